// File: rtl/text_overlay.sv
// Character-cell text box overlay on an RGB888 video stream.
// Three-stage pipeline: glyph ROM addressing, ROM capture, pixel select.
module text_overlay #(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int X_START  = 10,
  parameter int Y_START  = 10,
  parameter int CHAR_NUM = 8,
  parameter int GLYPH_W  = 16,
  parameter int GLYPH_H  = 24,
  parameter int CODE_W   = 7
) (
  input  logic                                  pixel_clk,
  input  logic                                  rst,
  input  logic                                  vs_in,
  input  logic                                  hs_in,
  input  logic                                  de_in,
  input  logic [23:0]                           pixel_in,
  input  logic                                  char_we,
  input  logic [$clog2(CHAR_NUM)-1:0]           char_waddr,
  input  logic [CODE_W-1:0]                     char_wdata,
  input  logic [23:0]                           front_colour,
  input  logic [23:0]                           back_colour,
  input  logic [1:0]                            scale_log2,
  input  logic                                  bg_transparent,
  input  logic                                  enable,
  output logic [CODE_W+$clog2(GLYPH_H)-1:0]     glyph_addr,
  input  logic [GLYPH_W-1:0]                    glyph_row,
  output logic                                  vs_out,
  output logic                                  hs_out,
  output logic                                  de_out,
  output logic [23:0]                           pixel_out
);

  localparam int HC_W   = $clog2(H_ACTIVE);
  localparam int VC_W   = $clog2(V_ACTIVE);
  localparam int SLOT_W = $clog2(CHAR_NUM);
  localparam int COL_W  = $clog2(GLYPH_W);
  localparam int ADDR_W = CODE_W + $clog2(GLYPH_H);
  localparam int unsigned H_MAX = H_ACTIVE - 1;
  localparam int unsigned V_MAX = V_ACTIVE - 1;
  localparam int unsigned XS    = X_START;
  localparam int unsigned YS    = Y_START;
  localparam int unsigned GH    = GLYPH_H;
  localparam int unsigned BOX_W = CHAR_NUM * GLYPH_W;
  localparam int unsigned BOX_H = GLYPH_H;

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  function automatic logic [23:0] sel_pixel(input logic in_box, input logic en,
                                            input logic glyph_bit, input logic transp,
                                            input logic [23:0] pix, input logic [23:0] front,
                                            input logic [23:0] back);
    if (!in_box || !en) return pix;
    if (glyph_bit)      return front;
    if (transp)         return pix;
    return back;
  endfunction

  logic [HC_W-1:0]   h_cnt;
  logic [VC_W-1:0]   v_cnt;
  logic              de_d, vs_d;
  logic              vs_rise, de_fall;

  logic [CODE_W-1:0] shadow   [CHAR_NUM];
  logic [CODE_W-1:0] act_code [CHAR_NUM];
  logic [1:0]        act_scale;
  logic [23:0]       act_front, act_back;
  logic              act_transp, act_en;

  int unsigned       box_w, box_h, lx, ly;
  logic              in_box;
  logic [CODE_W-1:0] code_sel;
  logic [ADDR_W-1:0] addr_nxt;

  logic [COL_W-1:0]  col_p0, col_p1;
  logic              inbox_p0, inbox_p1;
  logic              vs_p0, hs_p0, vld_p0, vs_p1, hs_p1, vld_p1;
  logic [23:0]       pix_p0, pix_p1;
  logic [GLYPH_W-1:0] row_p1;
  logic              glyph_bit;

  assign vs_rise = vs_in & ~vs_d;
  assign de_fall = de_d & ~de_in;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      de_d  <= 1'b0;
      vs_d  <= 1'b0;
    end else begin
      de_d <= de_in;
      vs_d <= vs_in;
      if (de_in)
        h_cnt <= HC_W'(sat_inc(32'(h_cnt), H_MAX));
      else if (de_fall)
        h_cnt <= '0;
      if (vs_rise)
        v_cnt <= '0;
      else if (de_fall)
        v_cnt <= VC_W'(sat_inc(32'(v_cnt), V_MAX));
    end
  end

  // A write landing on the frame-start edge is forwarded into the active copy.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHAR_NUM; i++) begin
        shadow[i]   <= '0;
        act_code[i] <= '0;
      end
      act_scale  <= '0;
      act_front  <= '0;
      act_back   <= '0;
      act_transp <= 1'b0;
      act_en     <= 1'b0;
    end else begin
      if (char_we)
        shadow[char_waddr] <= char_wdata;
      if (vs_rise) begin
        for (int i = 0; i < CHAR_NUM; i++)
          act_code[i] <= (char_we && (char_waddr == SLOT_W'(i))) ? char_wdata : shadow[i];
        act_scale  <= (scale_log2 == 2'd3) ? 2'd2 : scale_log2;
        act_front  <= front_colour;
        act_back   <= back_colour;
        act_transp <= bg_transparent;
        act_en     <= enable;
      end
    end
  end

  always_comb begin
    box_w    = BOX_W << act_scale;
    box_h    = BOX_H << act_scale;
    in_box   = de_in &&
               (32'(h_cnt) >= XS) && (32'(h_cnt) < XS + box_w) &&
               (32'(v_cnt) >= YS) && (32'(v_cnt) < YS + box_h);
    lx       = (32'(h_cnt) - XS) >> act_scale;
    ly       = (32'(v_cnt) - YS) >> act_scale;
    code_sel = act_code[SLOT_W'(lx >> COL_W)];
    addr_nxt = ADDR_W'(32'(code_sel) * GH + ly);
  end

  // GLYPH_W is a power of two, so GLYPH_W-1-col is simply ~col.
  assign glyph_bit = row_p1[~col_p1];

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      glyph_addr <= '0;
      col_p0     <= '0;
      inbox_p0   <= 1'b0;
      vs_p0      <= 1'b0;
      hs_p0      <= 1'b0;
      vld_p0     <= 1'b0;
      pix_p0     <= '0;
      row_p1     <= '0;
      col_p1     <= '0;
      inbox_p1   <= 1'b0;
      vs_p1      <= 1'b0;
      hs_p1      <= 1'b0;
      vld_p1     <= 1'b0;
      pix_p1     <= '0;
      vs_out     <= 1'b0;
      hs_out     <= 1'b0;
      de_out     <= 1'b0;
      pixel_out  <= '0;
    end else begin
      // stage 1: ROM address, column and delayed video
      if (in_box)
        glyph_addr <= addr_nxt;
      col_p0   <= COL_W'(lx);
      inbox_p0 <= in_box;
      vs_p0    <= vs_in;
      hs_p0    <= hs_in;
      vld_p0   <= de_in;
      pix_p0   <= pixel_in;
      // stage 2: ROM data capture
      row_p1   <= glyph_row;
      col_p1   <= col_p0;
      inbox_p1 <= inbox_p0;
      vs_p1    <= vs_p0;
      hs_p1    <= hs_p0;
      vld_p1   <= vld_p0;
      pix_p1   <= pix_p0;
      // stage 3: pixel select
      vs_out    <= vs_p1;
      hs_out    <= hs_p1;
      de_out    <= vld_p1;
      pixel_out <= sel_pixel(inbox_p1, act_en, glyph_bit, act_transp, pix_p1,
                             act_front, act_back);
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Randomized bench for text_overlay against a frame/pixel-coordinate reference model.
module tb_text_overlay;
  localparam int XS = 2, YS = 2, NSLOT = 8, GW = 16, GH = 24;
  localparam logic [23:0] FRONT = 24'hFF0000, BACK = 24'h0000FF;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        char_we = 1'b0;
  logic [2:0]  char_waddr = '0;
  logic [6:0]  char_wdata = '0;
  logic [23:0] front_colour = '0, back_colour = '0;
  logic [1:0]  scale_log2 = '0;
  logic        bg_transparent = 1'b0, enable = 1'b0;
  logic [11:0] glyph_addr;
  logic [15:0] glyph_row;
  logic        vs_out, hs_out, de_out;
  logic [23:0] pixel_out;

  logic [15:0] rom [0:4095];
  assign glyph_row = rom[glyph_addr];

  text_overlay #(.X_START(XS), .Y_START(YS)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .pixel_in(pixel_in), .char_we(char_we), .char_waddr(char_waddr), .char_wdata(char_wdata),
    .front_colour(front_colour), .back_colour(back_colour), .scale_log2(scale_log2),
    .bg_transparent(bg_transparent), .enable(enable), .glyph_addr(glyph_addr),
    .glyph_row(glyph_row), .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .pixel_out(pixel_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic vs; logic hs; logic de; logic [23:0] pix;
    logic [11:0] addr; bit achk; int x; int y;
  } rec_t;

  rec_t q[$];
  rec_t e_c, a_c;
  int n_chk = 0, n_err = 0;

  logic [6:0]  m_shadow [NSLOT];
  logic [6:0]  m_act    [NSLOT];
  bit          m_en, m_tr, track_ok, addr_known, m_vs_prev;
  int          m_sc;
  logic [23:0] m_front, m_back;
  logic [11:0] m_addr;

  bit          rnd_side = 0, pix_fix = 0, f_we = 0;
  logic [23:0] pix_val = '0;
  int          f_slot = 0, wr_y = -1, wr_slot = 0;
  logic [6:0]  f_code = '0, wr_code = '0;

  logic [23:0] lit_pix  [0:7][0:79];
  logic [11:0] lit_addr [0:7][0:79];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t zrec();
    rec_t r;
    r.vs = 0; r.hs = 0; r.de = 0; r.pix = '0; r.addr = '0; r.achk = 0; r.x = -1; r.y = -1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) begin m_shadow[i] = '0; m_act[i] = '0; end
    m_en = 0; m_tr = 0; m_sc = 0; m_front = '0; m_back = '0; m_addr = '0;
    track_ok = 0; m_vs_prev = 0;
    q.delete();
    q.push_back(zrec());
    q.push_back(zrec());
  endtask

  task automatic clr_lit();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 80; x++) begin lit_pix[y][x] = '1; lit_addr[y][x] = '1; end
  endtask

  // Output at posedge m (+1) carries the record driven two cycles earlier;
  // glyph_addr carries the record driven just before this edge.
  always @(posedge pixel_clk) begin
    #1;
    if (rst) begin
      check("rst_video", {vs_out, hs_out, de_out, pixel_out}, 64'h0);
      check("rst_addr", glyph_addr, 64'h0);
    end else if (q.size() >= 3) begin
      e_c = q[q.size()-3];
      a_c = q[q.size()-1];
      check("video", {vs_out, hs_out, de_out, pixel_out}, {e_c.vs, e_c.hs, e_c.de, e_c.pix});
      if (a_c.achk) check("glyph_addr", glyph_addr, a_c.addr);
      if (e_c.x >= 0 && e_c.x < 80 && e_c.y >= 0 && e_c.y < 8) lit_pix[e_c.y][e_c.x] = pixel_out;
      if (a_c.x >= 0 && a_c.x < 80 && a_c.y >= 0 && a_c.y < 8) lit_addr[a_c.y][a_c.x] = glyph_addr;
      while (q.size() > 3) void'(q.pop_front());
    end
  end

  task automatic cyc(input logic v, input logic h, input logic d, input int x, input int y);
    rec_t r;
    int s, lx, ly;
    logic [6:0] code;
    logic [15:0] row;
    bit inb, gbit;
    @(negedge pixel_clk);
    rst = 1'b0;
    vs_in = v; hs_in = h; de_in = d;
    pixel_in = pix_fix ? pix_val : 24'($urandom);
    char_we = 1'b0;
    if (rnd_side) begin
      char_we = ($urandom_range(0, 7) == 0);
      char_waddr = 3'($urandom);
      char_wdata = 7'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        front_colour = 24'($urandom); back_colour = 24'($urandom);
        scale_log2 = 2'($urandom); bg_transparent = 1'($urandom);
        enable = ($urandom_range(0, 3) != 0);
      end
    end
    if (f_we) begin char_we = 1'b1; char_waddr = 3'(f_slot); char_wdata = f_code; f_we = 0; end
    if (d && y == wr_y && x == 0) begin char_we = 1'b1; char_waddr = 3'(wr_slot); char_wdata = wr_code; end
    if (char_we) m_shadow[char_waddr] = char_wdata;
    if (v && !m_vs_prev) begin
      m_act = m_shadow; m_en = enable; m_tr = bg_transparent;
      m_sc = (scale_log2 == 2'd3) ? 2 : int'(scale_log2);
      m_front = front_colour; m_back = back_colour; track_ok = 1;
    end
    m_vs_prev = v;
    inb = 0; gbit = 0;
    if (d && track_ok) begin
      s = 1 << m_sc;
      if (x >= XS && x < XS + NSLOT * GW * s && y >= YS && y < YS + GH * s) begin
        inb = 1;
        lx = (x - XS) / s;
        ly = (y - YS) / s;
        code = m_act[lx / GW];
        m_addr = 12'(int'(code) * GH + ly);
        row = rom[m_addr];
        gbit = row[4'(GW - 1 - lx % GW)];
        addr_known = 1;
      end
    end
    r.vs = v; r.hs = h; r.de = d;
    r.x = d ? x : -1; r.y = d ? y : -1;
    r.addr = m_addr; r.achk = addr_known;
    if (!inb || !m_en) r.pix = pixel_in;
    else if (gbit)     r.pix = m_front;
    else if (m_tr)     r.pix = pixel_in;
    else               r.pix = m_back;
    q.push_back(r);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_vs_out", vs_out, 64'h0);
    check("async_rst_hs_out", hs_out, 64'h0);
    check("async_rst_de_out", de_out, 64'h0);
    check("async_rst_pixel_out", pixel_out, 64'h0);
    check("async_rst_glyph_addr", glyph_addr, 64'h0);
    model_reset();
    addr_known = 0;
  endtask

  task automatic frame(input int w, input int h, input int rst_line);
    repeat (2) cyc(1, 0, 0, -1, -1);
    repeat (4) cyc(0, 0, 0, -1, -1);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        cyc(0, 0, 1, x, y);
        if (y == rst_line && x == w / 2) mid_reset();
      end
      repeat (2) cyc(0, 1, 0, -1, -1);
      repeat (4) cyc(0, 0, 0, -1, -1);
    end
    repeat (4) cyc(0, 0, 0, -1, -1);
  endtask

  task automatic wr(input int slot, input logic [6:0] code);
    f_we = 1; f_slot = slot; f_code = code;
    cyc(0, 0, 0, -1, -1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    model_reset();
    addr_known = 1;
    repeat (3) @(posedge pixel_clk);

    // passthrough with overlay disabled
    enable = 0; pix_fix = 1; pix_val = 24'h123456;
    clr_lit(); frame(64, 16, -1);
    check("pass_pix_0_0", lit_pix[0][0], 64'h123456);
    check("pass_pix_5_10", lit_pix[5][10], 64'h123456);

    // single glyph row 0x8001 at scale 0
    rom[5 * GH] = 16'h8001;
    front_colour = FRONT; back_colour = BACK; bg_transparent = 0; scale_log2 = 0; enable = 1;
    pix_fix = 0;
    wr(0, 7'd5);
    clr_lit(); frame(40, 6, -1);
    check("glyph_x2", lit_pix[2][2], 64'(FRONT));
    check("glyph_x3", lit_pix[2][3], 64'(BACK));
    check("glyph_x16", lit_pix[2][16], 64'(BACK));
    check("glyph_x17", lit_pix[2][17], 64'(FRONT));
    check("glyph_addr_2_2", lit_addr[2][2], 64'd120);

    // scale 2x
    scale_log2 = 1;
    clr_lit(); frame(40, 8, -1);
    check("scale_x2", lit_pix[2][2], 64'(FRONT));
    check("scale_x3", lit_pix[2][3], 64'(FRONT));
    check("scale_y3_x2", lit_pix[3][2], 64'(FRONT));
    check("scale_x4", lit_pix[2][4], 64'(BACK));
    check("scale_x31", lit_pix[2][31], 64'(BACK));
    check("scale_x32", lit_pix[2][32], 64'(FRONT));
    check("scale_x33", lit_pix[2][33], 64'(FRONT));
    check("scale_addr_y3", lit_addr[3][2], 64'd120);
    check("scale_addr_y4", lit_addr[4][2], 64'd121);
    check("scale_addr_y5", lit_addr[5][2], 64'd121);
    check("scale_addr_y6", lit_addr[6][2], 64'd122);

    // mid-frame write only takes effect next frame
    scale_log2 = 0; wr_y = 1; wr_slot = 3; wr_code = 7'h41;
    clr_lit(); frame(70, 4, -1);
    check("latch_same_frame", lit_addr[2][50], 64'd0);
    wr_y = -1;
    clr_lit(); frame(70, 4, -1);
    check("latch_next_frame", lit_addr[2][50], 64'd1560);
    check("latch_next_frame_y3", lit_addr[3][50], 64'd1561);

    // transparent background with all-zero glyph rows
    for (int r = 0; r < GH; r++) rom[9 * GH + r] = 16'h0000;
    for (int s = 0; s < NSLOT; s++) wr(s, 7'd9);
    bg_transparent = 1; pix_fix = 1; pix_val = 24'hA5A5A5;
    clr_lit(); frame(40, 6, -1);
    check("transp_3_5", lit_pix[3][5], 64'hA5A5A5);
    check("transp_4_20", lit_pix[4][20], 64'hA5A5A5);

    // randomized frames, one with an asynchronous reset mid-line
    pix_fix = 0; rnd_side = 1;
    for (int f = 0; f < 8; f++)
      frame($urandom_range(20, 150), $urandom_range(4, 40), (f == 3) ? $urandom_range(1, 3) : -1);
    rnd_side = 0;
    repeat (4) cyc(0, 0, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
Parameters:
REQ-001 H_ACTIVE, 1920: maximum active pixels per line.
REQ-002 V_ACTIVE, 1080: maximum active lines per frame.
REQ-003 X_START, 10: left edge of the text box, in active-pixel coordinates.
REQ-004 Y_START, 10: top edge of the text box, in active-line coordinates.
REQ-005 CHAR_NUM, 8: number of character slots in one text line.
REQ-006 GLYPH_W, 16: glyph width in pixels; SHALL be a power of two.
REQ-007 GLYPH_H, 24: glyph height in pixels.
REQ-008 CODE_W, 7: character code width.

Ports:
REQ-009 pixel_clk, in, 1: the single clock.
REQ-010 rst, in, 1: asynchronous reset, active-high.
REQ-011 vs_in / hs_in / de_in, in, 1 each: input video syncs and data enable; vs_in is active-high.
REQ-012 pixel_in, in, 24: input RGB888 pixel.
REQ-013 char_we, in, 1: write strobe for the character shadow buffer.
REQ-014 char_waddr, in, clog2(CHAR_NUM): slot number to write.
REQ-015 char_wdata, in, CODE_W: character code to write.
REQ-016 front_colour / back_colour, in, 24 each: colour for glyph-set pixels / colour for glyph-clear pixels.
REQ-017 scale_log2, in, 2: glyph magnification is 2^scale_log2; codes 0..2 are valid and code 3 SHALL behave as 2.
REQ-018 bg_transparent, in, 1: when 1, glyph-clear pixels inside the box pass pixel_in.
REQ-019 enable, in, 1: overlay enable.
REQ-020 glyph_addr, out, CODE_W+clog2(GLYPH_H): external glyph ROM address, equal to code*GLYPH_H+row.
REQ-021 glyph_row, in, GLYPH_W: ROM data, valid one clock after glyph_addr; the MSB is the leftmost pixel.
REQ-022 vs_out / hs_out / de_out, out, 1 each: delayed syncs and data enable.
REQ-023 pixel_out, out, 24: output pixel.

Function
REQ-024 h_cnt SHALL increment on each de_in=1 cycle, clear on the de_in falling edge, and saturate at H_ACTIVE-1.
REQ-025 v_cnt SHALL increment on each de_in falling edge, clear on the vs_in rising edge, and saturate at V_ACTIVE-1.
REQ-026 A char_we write SHALL update the shadow buffer on the same edge; a write and a frame start in the same cycle SHALL include the new write in the copy.
REQ-027 On the vs_in rising edge, the shadow buffer, scale_log2, colours, bg_transparent and enable SHALL be copied to active registers; mid-frame changes SHALL have no visible effect.
REQ-028 A pixel is in the box when X_START <= h_cnt < X_START+CHAR_NUM*GLYPH_W*S and Y_START <= v_cnt < Y_START+GLYPH_H*S, with S=2^scale and de_in=1.
REQ-029 Local coordinates: lx=(h_cnt-X_START)>>scale, ly=(v_cnt-Y_START)>>scale, slot=lx/GLYPH_W, col=lx%GLYPH_W.
REQ-030 Pipeline stage 1 (edge 1) SHALL register glyph_addr={active code[slot]}*GLYPH_H+ly, plus col, the in-box flag and the delayed video.
REQ-031 Stage 2 (edge 2) SHALL capture glyph_row.
REQ-032 Stage 3 (edge 3) SHALL select pixel_out as follows:
- not in box, or active enable=0: pixel_in.
- glyph bit [GLYPH_W-1-col] set: front_colour.
- bit clear and bg_transparent=1: pixel_in.
- otherwise: back_colour.
REQ-033 vs_out/hs_out/de_out/pixel_out SHALL lag their inputs by exactly 3 cycles, with all four aligned.
REQ-034 glyph_addr SHALL hold its last value outside the box.
REQ-035 A frame shorter than the box SHALL render only the visible part, with no error.

Reset
REQ-036 rst=1 SHALL immediately clear: h_cnt, v_cnt, pipeline, shadow and active buffers (code 0), active enable, glyph_addr, vs_out/hs_out/de_out and pixel_out (0x000000).
REQ-037 Reset released mid-frame: the output SHALL stay pass-through (enable=0) until the first vs_in rising edge after release.

Verification
REQ-038 Passthrough: enable=0, 64x16 frame, pixel_in=0x123456 -> pixel_out=0x123456 and de_out equal to de_in delayed 3 cycles, every cycle.
REQ-039 Glyph render: X_START=Y_START=2, slot0=code 5, ROM row returns 0x8001, scale 0 -> at v_cnt=2, h_cnt 2 and 17 = front_colour, h_cnt 3..16 = back_colour.
REQ-040 Scale: scale_log2=1 -> each glyph bit covers 2x2 pixels, box width 2*CHAR_NUM*16, glyph_addr row changes every 2 lines.
REQ-041 Frame latching: write slot3=0x41 mid-frame -> glyph_addr for slot 3 shows code 0 in that frame and 0x41*GLYPH_H+ly in the next frame.
REQ-042 Transparency: bg_transparent=1, ROM returns 0 -> pixel_out inside the box equals pixel_in.
REQ-043 Async reset: assert rst mid-line -> all outputs 0 within the same cycle; counters restart from 0 after the next vs_in.
